// File: rtl/cmd_frame_pkg.sv
// Shared FSM state encoding, default header bytes and length check for the command frame decoder.
package cmd_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_LEN  = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_WR_DONE = 3'd3,
        ST_RD_LEN  = 3'd4,
        ST_WR_CHK  = 3'd5,
        ST_RD_CHK  = 3'd6
    } state_t;

    localparam logic [7:0] DEF_WR_HDR = 8'h55;
    localparam logic [7:0] DEF_RD_HDR = 8'hAA;

    function automatic logic len_valid(input logic [7:0] len, input logic [7:0] max_len);
        return (len != 8'h00) && (len <= max_len);
    endfunction

endpackage

// File: rtl/cmd_byte_timer.sv
// Inter-byte idle timer: counts while enabled, clears on restart or while disabled.
// Latency: expire is decoded combinationally from the count register.
// Backpressure: none; restart always takes priority over expiry.
module cmd_byte_timer #(
    parameter int TIMEOUT_CYC = 50000,
    parameter int TO_W        = 16
) (
    input  logic s_clk,
    input  logic s_rst_n,
    input  logic en,
    input  logic restart,
    output logic expire
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            cnt <= '0;
        end else if (restart || !en) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + TO_W'(1);
        end
    end

    assign expire = en && (cnt == LAST);

endmodule

// File: rtl/cmd_frame_decode.sv
// Length-prefixed write/read command frame decoder feeding the SDRAM write FIFO and arbiter.
// Latency: every output is registered, one cycle after the uart_flag that causes it (wr_trig two).
// Backpressure: none; one byte per uart_flag. Optional trailing checksum under CMD_CHKSUM_EN.
module cmd_frame_decode
    import cmd_frame_pkg::*;
#(
    parameter logic [7:0] WR_HDR      = DEF_WR_HDR,
    parameter logic [7:0] RD_HDR      = DEF_RD_HDR,
    parameter int         MAX_LEN     = 16,
    parameter int         LEN_W       = 8,
    parameter int         TIMEOUT_CYC = 50000,
    parameter int         TO_W        = 16
) (
    input  logic             s_clk,
    input  logic             s_rst_n,
    input  logic             uart_flag,
    input  logic [7:0]       uart_data,
    output logic             wr_trig,
    output logic [LEN_W-1:0] wr_len,
    output logic             rd_trig,
    output logic [LEN_W-1:0] rd_len,
    output logic             wfifo_wr_en,
    output logic [7:0]       wfifo_data,
    output logic             wfifo_clr,
    output logic             frame_err,
    output logic             busy
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t           state, state_nxt;
    logic [LEN_W-1:0] cnt, cnt_nxt;
    logic [LEN_W-1:0] wr_len_nxt, rd_len_nxt;
    logic [7:0]       wfifo_data_nxt;
    logic             wr_trig_nxt, rd_trig_nxt, wfifo_wr_en_nxt, wfifo_clr_nxt, frame_err_nxt;
    logic             len_ok;
    logic             expire;
`ifdef CMD_CHKSUM_EN
    logic [7:0]       chk, chk_nxt;
`endif

    cmd_byte_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_timer (
        .s_clk   (s_clk),
        .s_rst_n (s_rst_n),
        .en      (state != ST_IDLE),
        .restart (uart_flag),
        .expire  (expire)
    );

    assign len_ok = len_valid(uart_data, MAX_LEN_B);

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        wr_len_nxt      = wr_len;
        rd_len_nxt      = rd_len;
        wfifo_data_nxt  = wfifo_data;
        wr_trig_nxt     = 1'b0;
        rd_trig_nxt     = 1'b0;
        wfifo_wr_en_nxt = 1'b0;
        wfifo_clr_nxt   = 1'b0;
        frame_err_nxt   = 1'b0;
`ifdef CMD_CHKSUM_EN
        chk_nxt         = chk;
`endif
        // A byte always beats a same-cycle expiry, so every state tests uart_flag first.
        case (state)
            ST_IDLE: begin
                if (uart_flag) begin
                    if (uart_data == WR_HDR) begin
                        state_nxt = ST_WR_LEN;
                    end else if (uart_data == RD_HDR) begin
                        state_nxt = ST_RD_LEN;
                    end
                end
            end
            ST_WR_LEN: begin
                if (uart_flag) begin
                    if (len_ok) begin
                        wr_len_nxt = LEN_W'(uart_data);
                        cnt_nxt    = '0;
                        state_nxt  = ST_WR_DATA;
`ifdef CMD_CHKSUM_EN
                        chk_nxt    = uart_data;
`endif
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = ST_IDLE;
                    end
                end else if (expire) begin
                    frame_err_nxt = 1'b1;
                    state_nxt     = ST_IDLE;
                end
            end
            ST_WR_DATA: begin
                if (uart_flag) begin
                    wfifo_wr_en_nxt = 1'b1;
                    wfifo_data_nxt  = uart_data;
                    cnt_nxt         = cnt + LEN_W'(1);
`ifdef CMD_CHKSUM_EN
                    chk_nxt         = chk + uart_data;
                    if (cnt == wr_len - LEN_W'(1)) state_nxt = ST_WR_CHK;
`else
                    if (cnt == wr_len - LEN_W'(1)) state_nxt = ST_WR_DONE;
`endif
                end else if (expire) begin
                    frame_err_nxt = 1'b1;
                    wfifo_clr_nxt = (cnt != '0);
                    state_nxt     = ST_IDLE;
                end
            end
            // Transient: lets wr_trig trail the final push by one cycle.
            ST_WR_DONE: begin
                wr_trig_nxt = 1'b1;
                state_nxt   = ST_IDLE;
            end
            ST_RD_LEN: begin
                if (uart_flag) begin
                    if (len_ok) begin
                        rd_len_nxt = LEN_W'(uart_data);
`ifdef CMD_CHKSUM_EN
                        chk_nxt    = uart_data;
                        state_nxt  = ST_RD_CHK;
`else
                        rd_trig_nxt = 1'b1;
                        state_nxt   = ST_IDLE;
`endif
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = ST_IDLE;
                    end
                end else if (expire) begin
                    frame_err_nxt = 1'b1;
                    state_nxt     = ST_IDLE;
                end
            end
`ifdef CMD_CHKSUM_EN
            ST_WR_CHK: begin
                if (uart_flag) begin
                    if (uart_data == chk) begin
                        wr_trig_nxt = 1'b1;
                    end else begin
                        frame_err_nxt = 1'b1;
                        wfifo_clr_nxt = 1'b1;
                    end
                    state_nxt = ST_IDLE;
                end else if (expire) begin
                    frame_err_nxt = 1'b1;
                    wfifo_clr_nxt = 1'b1;
                    state_nxt     = ST_IDLE;
                end
            end
            ST_RD_CHK: begin
                if (uart_flag) begin
                    if (uart_data == chk) begin
                        rd_trig_nxt = 1'b1;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                    state_nxt = ST_IDLE;
                end else if (expire) begin
                    frame_err_nxt = 1'b1;
                    state_nxt     = ST_IDLE;
                end
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            wr_len      <= '0;
            rd_len      <= '0;
            wfifo_data  <= '0;
            wr_trig     <= 1'b0;
            rd_trig     <= 1'b0;
            wfifo_wr_en <= 1'b0;
            wfifo_clr   <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            wr_len      <= wr_len_nxt;
            rd_len      <= rd_len_nxt;
            wfifo_data  <= wfifo_data_nxt;
            wr_trig     <= wr_trig_nxt;
            rd_trig     <= rd_trig_nxt;
            wfifo_wr_en <= wfifo_wr_en_nxt;
            wfifo_clr   <= wfifo_clr_nxt;
            frame_err   <= frame_err_nxt;
            busy        <= (state_nxt != ST_IDLE);
        end
    end

`ifdef CMD_CHKSUM_EN
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            chk <= '0;
        end else begin
            chk <= chk_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_cmd_frame_decode.sv
// Directed bench for cmd_frame_decode with TIMEOUT_CYC=100 and MAX_LEN=16; outputs sampled on the falling edge.
module tb_cmd_frame_decode;

    logic       s_clk = 1'b0;
    logic       s_rst_n;
    logic       uart_flag;
    logic [7:0] uart_data;
    logic       wr_trig, rd_trig, wfifo_wr_en, wfifo_clr, frame_err, busy;
    logic [7:0] wr_len, rd_len, wfifo_data;

    int errors = 0;
    int checks = 0;

    cmd_frame_decode #(
        .MAX_LEN     (16),
        .LEN_W       (8),
        .TIMEOUT_CYC (100),
        .TO_W        (16)
    ) dut (
        .s_clk       (s_clk),
        .s_rst_n     (s_rst_n),
        .uart_flag   (uart_flag),
        .uart_data   (uart_data),
        .wr_trig     (wr_trig),
        .wr_len      (wr_len),
        .rd_trig     (rd_trig),
        .rd_len      (rd_len),
        .wfifo_wr_en (wfifo_wr_en),
        .wfifo_data  (wfifo_data),
        .wfifo_clr   (wfifo_clr),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 s_clk = ~s_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge s_clk);
    endtask

    // Called at a falling edge; returns at the falling edge where the byte's response is visible.
    task automatic send_byte(input logic [7:0] b);
        uart_data = b;
        uart_flag = 1'b1;
        @(negedge s_clk);
        uart_flag = 1'b0;
        uart_data = 8'h00;
    endtask

    task automatic push_byte(input string tag, input logic [7:0] b);
        send_byte(b);
        check({tag, "_wr_en"}, wfifo_wr_en, 1);
        check({tag, "_data"}, wfifo_data, b);
    endtask

    // Completes a write frame after its last payload byte has been pushed.
    task automatic end_write(input string tag, input logic [7:0] chk, input logic [7:0] len_exp);
`ifdef CMD_CHKSUM_EN
        send_byte(chk);
`else
        tick();
`endif
        check({tag, "_wr_trig"}, wr_trig, 1);
        check({tag, "_wr_len"}, wr_len, len_exp);
        check({tag, "_no_err"}, frame_err, 0);
        tick();
        check({tag, "_trig_low"}, wr_trig, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    // Completes a read frame after its LEN byte.
    task automatic end_read(input string tag, input logic [7:0] chk, input logic [7:0] len_exp);
`ifdef CMD_CHKSUM_EN
        send_byte(chk);
`endif
        check({tag, "_rd_trig"}, rd_trig, 1);
        check({tag, "_rd_len"}, rd_len, len_exp);
        check({tag, "_no_push"}, wfifo_wr_en, 0);
        tick();
        check({tag, "_trig_low"}, rd_trig, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        s_rst_n   = 1'b0;
        uart_flag = 1'b0;
        uart_data = 8'h00;
        repeat (3) tick();
        check("rst_outputs", {wr_trig, rd_trig, wfifo_wr_en, wfifo_clr, frame_err, busy}, 0);
        check("rst_lens", {wr_len, rd_len, wfifo_data}, 0);
        s_rst_n = 1'b1;
        tick();

        // Basic write frame 55 04 13 15 32 26
        send_byte(8'h55);
        check("wr_hdr_busy", busy, 1);
        send_byte(8'h04);
        check("wr_len_no_push", wfifo_wr_en, 0);
        push_byte("wr_d0", 8'h13);
        push_byte("wr_d1", 8'h15);
        push_byte("wr_d2", 8'h32);
        push_byte("wr_d3", 8'h26);
        check("wr_d3_no_trig_yet", wr_trig, 0);
        end_write("wr4", 8'h84, 8'h04);

        // Read frame AA 08, then MAX_LEN boundary AA 10
        send_byte(8'hAA);
        send_byte(8'h08);
        end_read("rd8", 8'h08, 8'h08);
        send_byte(8'hAA);
        send_byte(8'h10);
        end_read("rd16", 8'h10, 8'h10);

        // Invalid lengths 55 00 and AA 11
        send_byte(8'h55);
        send_byte(8'h00);
        check("len0_err", frame_err, 1);
        check("len0_no_trig", wr_trig, 0);
        tick();
        check("len0_idle", busy, 0);
        check("len0_wr_len_held", wr_len, 8'h04);
        send_byte(8'hAA);
        send_byte(8'h11);
        check("len17_err", frame_err, 1);
        check("len17_no_trig", rd_trig, 0);
        tick();
        check("len17_idle", busy, 0);
        check("len17_rd_len_held", rd_len, 8'h10);

        // Byte arriving exactly on expiry is accepted, then silence times out
        send_byte(8'h55);
        send_byte(8'h04);
        push_byte("to_d0", 8'h13);
        repeat (99) tick();
        push_byte("to_flag_wins", 8'h15);
        check("to_flag_wins_no_err", frame_err, 0);
        repeat (99) tick();
        check("to_before_err", frame_err, 0);
        check("to_before_busy", busy, 1);
        tick();
        check("to_err", frame_err, 1);
        check("to_clr", wfifo_clr, 1);
        check("to_idle", busy, 0);
        check("to_no_trig", wr_trig, 0);
        tick();
        check("to_err_pulse", frame_err, 0);

        send_byte(8'h55);
        send_byte(8'h01);
        push_byte("post_to", 8'h7E);
        end_write("post_to", 8'h7F, 8'h01);

        // Timeout in WR_DATA before any payload: error without flush
        send_byte(8'h55);
        send_byte(8'h04);
        repeat (100) tick();
        check("to0_err", frame_err, 1);
        check("to0_no_clr", wfifo_clr, 0);

        // Garbage before a frame is ignored
        tick();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h12);
        check("garbage_idle", busy, 0);
        check("garbage_no_err", frame_err, 0);
        send_byte(8'h55);
        send_byte(8'h01);
        push_byte("garb_frame", 8'hAA);
        end_write("garb_frame", 8'hAB, 8'h01);

        // Header values inside payload are data
        send_byte(8'h55);
        send_byte(8'h02);
        push_byte("hdr_pay0", 8'h55);
        push_byte("hdr_pay1", 8'hAA);
        end_write("hdr_pay", 8'h01, 8'h02);

`ifdef CMD_CHKSUM_EN
        send_byte(8'h55);
        send_byte(8'h02);
        push_byte("chk_ok0", 8'h10);
        push_byte("chk_ok1", 8'h20);
        end_write("chk_ok", 8'h32, 8'h02);
        send_byte(8'h55);
        send_byte(8'h02);
        push_byte("chk_bad0", 8'h10);
        push_byte("chk_bad1", 8'h20);
        send_byte(8'h33);
        check("chk_bad_err", frame_err, 1);
        check("chk_bad_clr", wfifo_clr, 1);
        check("chk_bad_no_trig", wr_trig, 0);
        tick();
`endif

        // Reset mid-frame drops straight to idle with no trig or flush
        send_byte(8'h55);
        send_byte(8'h02);
        push_byte("mid_rst", 8'h11);
        s_rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pulses", {wr_trig, wfifo_clr, frame_err, wfifo_wr_en}, 0);
        check("mid_rst_wr_len", wr_len, 0);
        tick();
        s_rst_n = 1'b1;
        tick();
        repeat (5) tick();
        check("mid_rst_quiet", {wr_trig, wfifo_clr, frame_err, busy}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
